// File: rtl/multi_prescalar.sv
// Runtime-programmable multi-channel clock-enable generator. Each channel
// is a phase accumulator that emits a one-cycle strobe on every carry.
//
// Ports:
//   clk0    : system clock (32 MHz)
//   rstn    : synchronous active-low reset
//   ch_en   : per-channel run enable
//   sync    : clears every accumulator (phase align)
//   wr_en   : increment write strobe
//   wr_ch   : target channel of the write
//   wr_data : new increment value
//   strobe  : one-cycle enable pulse per channel
//   pend    : a written increment is waiting to be applied
//   sq_out  : ~50% duty square wave per channel
//
// Optional: define PRESCALAR_SQUARE_EN to build the sq_out registers;
// otherwise sq_out is tied low.

module multi_prescalar #(
  parameter int          NUM_CH  = 3,
  parameter int          ACC_W   = 24,
  parameter int unsigned INC_RST = 0
) (
  input  logic              clk0,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [ACC_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] strobe,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] sq_out
);

  localparam logic [3:0]       NCH      = 4'(NUM_CH);
  localparam logic [ACC_W-1:0] INC_INIT = ACC_W'(INC_RST);

  logic wr_ok;

  // Writes to channels that do not exist are dropped.
  assign wr_ok = wr_en & ({1'b0, wr_ch} < NCH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [2:0] IDX = 3'(i);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] nxt_q;
    logic             str_q;
    logic             pnd_q;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_d;
    logic             run;
    logic             carry;
    logic             hit;
    logic             apply;

    assign run   = ch_en[i] & ~sync;
    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry = sum[ACC_W];
    assign acc_d = run ? sum[ACC_W-1:0] : '0;
    assign hit   = wr_ok & (wr_ch == IDX);

    // New increments only land at a phase boundary (carry) or while the
    // channel is not producing strobes, so no runt period is emitted.
    assign apply = pnd_q &
                   (~run | carry | (inc_q == '0));

    always_ff @(posedge clk0) begin
      if (!rstn) begin
        acc_q <= '0;
        inc_q <= INC_INIT;
        nxt_q <= '0;
        str_q <= 1'b0;
        pnd_q <= 1'b0;
      end else begin
        acc_q <= acc_d;
        str_q <= run & carry;
        if (apply) begin
          inc_q <= nxt_q;
        end
        if (hit) begin
          nxt_q <= wr_data;
        end
        // A write on the apply edge re-arms pend for the new value.
        if (hit) begin
          pnd_q <= 1'b1;
        end else if (apply) begin
          pnd_q <= 1'b0;
        end
      end
    end

    assign strobe[i] = str_q;
    assign pend[i]   = pnd_q;

`ifdef PRESCALAR_SQUARE_EN
    logic sq_q;

    // MSB of the next accumulator value: high for the second half of
    // each phase period; acc_d is already zero on sync / disable.
    always_ff @(posedge clk0) begin
      if (!rstn) begin
        sq_q <= 1'b0;
      end else begin
        sq_q <= acc_d[ACC_W-1];
      end
    end

    assign sq_out[i] = sq_q;
`endif
  end

`ifndef PRESCALAR_SQUARE_EN
  assign sq_out = '0;
`endif

endmodule

// File: tb/tb_multi_prescalar.sv
// Scoreboard bench for multi_prescalar: expected strobe edges are queued
// per channel by the stimulus and consumed by an independent monitor.

module tb_multi_prescalar;

  localparam int NUM_CH = 3;
  localparam int ACC_W  = 24;
`ifdef PRESCALAR_SQUARE_EN
  localparam int SQ_EXP = 16;
`else
  localparam int SQ_EXP = 0;
`endif

  logic              clk0;
  logic              rstn;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              wr_en;
  logic [2:0]        wr_ch;
  logic [ACC_W-1:0]  wr_data;
  logic [NUM_CH-1:0] strobe;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] sq_out;

  int cyc;
  int n_chk;
  int n_fail;
  int sq_hi;
  int expq [NUM_CH][$];

  multi_prescalar #(
    .NUM_CH (NUM_CH),
    .ACC_W  (ACC_W),
    .INC_RST(0)
  ) dut (
    .clk0   (clk0),
    .rstn   (rstn),
    .ch_en  (ch_en),
    .sync   (sync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_data(wr_data),
    .strobe (strobe),
    .pend   (pend),
    .sq_out (sq_out)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  // Edge counter: after posedge N settles, cyc == N.
  always @(posedge clk0) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the head of its queue, and
  // a queued edge that passes without a strobe is a miss.
  always @(negedge clk0) begin
    for (int c = 0; c < NUM_CH; c++) begin
      while (expq[c].size() > 0 && expq[c][0] < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL strobe%0d_missed: none at edge %0d, required 1",
                 c, expq[c][0]);
        void'(expq[c].pop_front());
      end
      if (strobe[c] === 1'b1) begin
        n_chk++;
        if (expq[c].size() > 0 && expq[c][0] == cyc) begin
          void'(expq[c].pop_front());
        end else begin
          n_fail++;
          $display("FAIL strobe%0d_unexpected: 1 at edge %0d, required 0",
                   c, cyc);
        end
      end
    end
  end

  always @(negedge clk0) begin
    if (cyc >= 8 && cyc <= 39 && sq_out[0] === 1'b1) sq_hi++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at edge %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) step();
  endtask

  task automatic wr(input int e, input logic [2:0] ch,
                    input logic [ACC_W-1:0] d);
    run_to(e - 1);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic push_seq(input int ch, input int first,
                          input int stp, input int last);
    for (int e = first; e <= last; e += stp) expq[ch].push_back(e);
  endtask

  initial begin
    rstn    = 1'b0;
    ch_en   = '0;
    sync    = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_data = '0;

    run_to(3);
    chk("rst_strobe", 32'(strobe), 32'h0);
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_sq", 32'(sq_out), 32'h0);

    // ch0 at 2^24/32: applies on edge 7, strobes every 32 from there.
    rstn  = 1'b1;
    ch_en = 3'b001;
    push_seq(0, 39, 32, 135);
    wr(6, 3'd0, 24'd524288);
    chk("pend_set", 32'(pend), 32'h1);
    step();
    chk("pend_apply_idle", 32'(pend), 32'h0);

    // Mid-period change to 16: held until the carry at 167.
    push_seq(0, 167, 16, 231);
    wr(145, 3'd0, 24'd1048576);
    run_to(166);
    chk("pend_hold", 32'(pend), 32'h1);
    step();
    chk("pend_clr_carry", 32'(pend), 32'h0);

    // Two writes then an out-of-range one; the last ch0 write wins.
    push_seq(0, 235, 4, 303);
    wr(220, 3'd0, 24'd2097152);
    wr(221, 3'd0, 24'd4194304);
    wr(222, 3'd5, 24'd1);
    chk("pend_ch5_ignored", 32'(pend), 32'h1);
    run_to(230);
    chk("pend_last_wins", 32'(pend), 32'h1);
    step();
    chk("pend_clr_231", 32'(pend), 32'h0);

    // ch1 at 2^23 (period 2), ch2 at 3355443 (first 6, then 5).
    push_seq(1, 258, 2, 304);
    push_seq(2, 263, 5, 303);
    run_to(254);
    ch_en   = 3'b011;
    wr_en   = 1'b1;
    wr_ch   = 3'd1;
    wr_data = 24'd8388608;
    step();
    ch_en   = 3'b111;
    wr_ch   = 3'd2;
    wr_data = 24'd3355443;
    step();
    wr_en   = 1'b0;

    // Sync at 306 swallows ch1's strobe; all restart from zero phase.
    push_seq(0, 310, 4, 322);
    push_seq(1, 308, 2, 324);
    push_seq(2, 312, 5, 322);
    run_to(305);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_strobe", 32'(strobe), 32'h0);

    // Pending write, then reset on an edge where ch0 and ch1 would fire.
    wr(325, 3'd0, 24'd1000);
    chk("pend_before_rst", 32'(pend), 32'h1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("midrst_strobe", 32'(strobe), 32'h0);
    chk("midrst_pend", 32'(pend), 32'h0);
    chk("midrst_sq", 32'(sq_out), 32'h0);

    // Increments back at zero: no further strobes may appear.
    run_to(370);
    chk("post_rst_pend", 32'(pend), 32'h0);
    chk("sq_high_cycles", 32'(sq_hi), 32'(SQ_EXP));
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("queue%0d_drained", c), 32'(expq[c].size()), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_prescalar.md
Name: multi_prescalar

Overview:
- Parametrised, runtime-programmable clock-enable generator. Replaces fixed DCM divide ratios with NUM_CH independent fractional dividers, each a phase accumulator.
- Runs entirely in the buffered 32 MHz system clock domain (clk0). Emits one-cycle enable strobes for SPI, NCO and envelope logic, so no extra global clock buffers are needed.
- Divide ratios can change on the fly without runt or glitch strobes.

Parameters:
- NUM_CH, 3, number of independent divider channels (1..8).
- ACC_W, 24, phase accumulator width in bits (8..32). Strobe frequency = f_clk0 * inc / 2^ACC_W.
- INC_RST, 0, increment value loaded into every channel at reset (0 = channel idle).

Ports:
- clk0  in  1  system clock (32 MHz).
- rstn  in  1  synchronous active-low reset.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  phase-align pulse: clears all accumulators.
- wr_en  in  1  increment write strobe.
- wr_ch  in  3  target channel index.
- wr_data  in  ACC_W  new increment value.
- strobe  out  NUM_CH  one-cycle clock-enable pulse per channel.
- pend  out  NUM_CH  per-channel flag: a written increment is waiting to be applied.
- sq_out  out  NUM_CH  ~50% duty square wave per channel (optional feature).

Behaviour:
- Reset (rstn=0 at a clk0 edge), all channels:
  - acc=0, inc=INC_RST, pending value=0, pend=0, strobe=0, sq_out=0.
  - Reset mid-operation discards pending writes and in-flight strobes on that edge.
- Per channel i, on each clk0 edge with rstn=1:
  - If sync=1: acc_i<=0 and strobe_i<=0. sync has priority over ch_en.
  - Else if ch_en[i]=0: acc_i<=0, strobe_i<=0.
  - Else: {carry,acc_i} <= acc_i + inc_i (ACC_W+1-bit sum, modulo wrap), strobe_i <= carry.
- Strobe timing:
  - strobe is registered and high for exactly one cycle.
  - Period is exactly 2^ACC_W/inc cycles when that ratio is an integer. Otherwise periods alternate between floor and ceil, and the long-run average is exact.
  - First strobe appears ceil(2^ACC_W/inc) edges after the first enabled edge.
  - inc=0 gives no strobes; acc holds its value.
- Write port:
  - wr_en=1 with wr_ch<NUM_CH: pending_ch<=wr_data, pend[ch]<=1.
  - wr_en=1 with wr_ch>=NUM_CH: ignored, no state change.
  - Repeated writes before apply: the last write wins.
- Apply (glitch-free update), when pend[i]=1:
  - inc_i<=pending_i and pend[i]<=0 on the first edge where any of these holds: the channel's add produces carry; ch_en[i]=0; inc_i=0; sync=1.
  - The add on the apply edge uses the old inc; the new inc takes effect from the next edge. acc is not cleared on apply.
  - Write and apply on the same edge, same channel: the previously pending value is applied, the new wr_data becomes pending, and pend stays 1.
- Channels are fully independent apart from the shared sync and write port.

Optional Feature:
- Macro: PRESCALAR_SQUARE_EN.
- Defined: sq_out[i] is a register loaded each edge with the MSB of the next acc_i value.
  - Gives a ~50% duty square wave at the strobe frequency, usable as a fabric-routed slow clock or test-pin output.
  - Cleared on reset, sync, and ch_en[i]=0.
- Undefined: sq_out is tied to all zeros and no extra registers are built.

Test Plan:
- Reset then enable ch0 at INC_RST=0, write inc=524288 (2^24/32) -> pend[0] clears 1 cycle after write; first strobe[0] 32 edges after write applied; then exactly every 32 cycles (1 MHz).
- ch1 inc=8388608 (2^23) -> strobe[1] every 2 cycles (16 MHz). ch2 inc=3355443 -> strobe periods 5 cycles ±1, average 5.000 over 1e6 cycles within 1 strobe.
- ch0 running at 524288, write 1048576 mid-period -> pend[0]=1 until next strobe; spacing is 32 up to that strobe, then 16; no period shorter than 16.
- Write to wr_ch=5 with NUM_CH=3 -> no pend bit set, all inc unchanged. Two writes to ch0 before carry -> last value applied.
- Pulse sync while all channels run -> all acc=0 next edge, no strobes that cycle; all channels' next strobes are phase-aligned (inc 2^23 and 2^22 strobe together every 4 cycles). Assert rstn=0 mid-run -> strobe, pend, sq_out all 0 next edge.
- With PRESCALAR_SQUARE_EN, inc=524288 -> sq_out[0] high 16, low 16 cycles. Without the macro -> sq_out stays 0.
